// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter slice: RAM geometry and the
// ResultSrc encoding that marks a core load.
package dmem_pkg;

  localparam int AW        = 5;
  localparam int DW        = 32;
  localparam int RAM_DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// External requester port of the data-memory arbiter (debug/loader side).
interface dmem_arbiter_if;
  import dmem_pkg::*;

  // Handshake: the master raises ext_req with ext_we/ext_addr/ext_wdata and
  // holds all four stable until it samples ext_gnt high. The access commits at
  // the clock edge that ends the ext_gnt cycle. For a read, ext_rvalid pulses
  // for exactly the following cycle with ext_rdata. A new request may follow
  // in the cycle right after a grant.
  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt;
  logic [DW-1:0] ext_rdata;
  logic          ext_rvalid;

  modport master (
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rdata, ext_rvalid
  );

  modport slave (
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rdata, ext_rvalid
  );

endinterface

// File: rtl/dmem_starve_ctr.sv
// Tracks how long the external requester has waited behind the core and
// marks the single cycle the core is owed after a forced grant.
module dmem_starve_ctr #(
  parameter  int STARVE_LIMIT = 4,
  localparam int WCW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ext_req,
  input  logic           core_access,
  input  logic           ext_gnt,
  output logic           starve,
  output logic           core_owed,
  output logic [WCW-1:0] wait_cnt
);

  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           core_owed_q, core_owed_d;

  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    core_owed_d = ext_gnt & core_access;
    if (ext_gnt || !ext_req) begin
      wait_cnt_d = '0;
    end else if (core_access && (wait_cnt_q != WCW'(STARVE_LIMIT))) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= '0;
      core_owed_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      core_owed_q <= core_owed_d;
    end
  end

  assign starve    = (wait_cnt_q == WCW'(STARVE_LIMIT));
  assign core_owed = core_owed_q;
  assign wait_cnt  = wait_cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data RAM between the single-cycle core (priority) and an external
// requester; a starved requester steals one cycle by stalling the core.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter  int STARVE_LIMIT = 4,
  localparam int WCW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           core_we,
  input  logic           core_re,
  input  logic [AW-1:0]  core_addr,
  input  logic [DW-1:0]  core_wdata,
  output logic [DW-1:0]  core_rdata,
  output logic           core_stall,
  dmem_arbiter_if.slave  ext,
  output logic           ram_we,
  output logic [AW-1:0]  ram_addr,
  output logic [DW-1:0]  ram_wdata,
  input  logic [DW-1:0]  ram_rdata,
  output logic [7:0]     gnt_count,
  output logic [WCW-1:0] dbg_wait_cnt,
  output logic           dbg_core_owed
);

  logic          core_access;
  logic          starve;
  logic          core_owed;
  logic          gnt;
  logic [DW-1:0] ext_rdata_q, ext_rdata_d;
  logic          ext_rvalid_q, ext_rvalid_d;
  logic [7:0]    gnt_count_q, gnt_count_d;

  assign core_access = core_we | core_re;

  dmem_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_ctr (
    .clk         (clk),
    .reset       (reset),
    .ext_req     (ext.ext_req),
    .core_access (core_access),
    .ext_gnt     (gnt),
    .starve      (starve),
    .core_owed   (core_owed),
    .wait_cnt    (dbg_wait_cnt)
  );

  // A stalled core store is masked so only one port ever writes per cycle.
  always_comb begin
    gnt        = ext.ext_req & ~core_owed & (~core_access | starve);
    core_stall = gnt & core_access;
    ram_we     = core_we & ~core_stall;
    ram_addr   = core_addr;
    ram_wdata  = core_wdata;
    if (gnt) begin
      ram_we    = ext.ext_we;
      ram_addr  = ext.ext_addr;
      ram_wdata = ext.ext_wdata;
    end
  end

  always_comb begin
    ext_rdata_d  = ext_rdata_q;
    ext_rvalid_d = gnt & ~ext.ext_we;
    gnt_count_d  = gnt_count_q;
    if (gnt && !ext.ext_we) begin
      ext_rdata_d = ram_rdata;
    end
    if (gnt) begin
      gnt_count_d = gnt_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_rdata_q  <= '0;
      ext_rvalid_q <= 1'b0;
      gnt_count_q  <= '0;
    end else begin
      ext_rdata_q  <= ext_rdata_d;
      ext_rvalid_q <= ext_rvalid_d;
      gnt_count_q  <= gnt_count_d;
    end
  end

  assign core_rdata     = ram_rdata;
  assign ext.ext_gnt    = gnt;
  assign ext.ext_rdata  = ext_rdata_q;
  assign ext.ext_rvalid = ext_rvalid_q;
  assign gnt_count      = gnt_count_q;
  assign dbg_core_owed  = core_owed;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM and a RAM model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int LIM = 4;
  localparam int WCW = $clog2(LIM + 1);

  logic           clk;
  logic           reset;
  logic           core_we, core_re;
  logic [AW-1:0]  core_addr;
  logic [DW-1:0]  core_wdata, core_rdata;
  logic           core_stall;
  logic           ram_we;
  logic [AW-1:0]  ram_addr;
  logic [DW-1:0]  ram_wdata, ram_rdata;
  logic [7:0]     gnt_count;
  logic [WCW-1:0] dbg_wait_cnt;
  logic           dbg_core_owed;

  dmem_arbiter_if ext_bus ();

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk           (clk),
    .reset         (reset),
    .core_we       (core_we),
    .core_re       (core_re),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_rdata    (core_rdata),
    .core_stall    (core_stall),
    .ext           (ext_bus.slave),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata),
    .gnt_count     (gnt_count),
    .dbg_wait_cnt  (dbg_wait_cnt),
    .dbg_core_owed (dbg_core_owed)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural RAM with asynchronous read
  logic [DW-1:0] ram [RAM_DEPTH] = '{default: '0};
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;
  assign ram_rdata = ram[ram_addr];

  // scoreboard state
  logic [DW-1:0] exp_mem [RAM_DEPTH];
  logic [DW-1:0] exp_q [$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic we, input logic re, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_we = we; core_re = re; core_addr = a; core_wdata = d;
  endtask

  task automatic set_ext(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ext_bus.ext_req = req; ext_bus.ext_we = we; ext_bus.ext_addr = a; ext_bus.ext_wdata = d;
  endtask

  initial begin : stim
    int grants, cycles, ext_wait, bad_words;
    logic ext_pending, core_retry, prev_stall;
    logic [DW-1:0] popped;
    int op;

    set_core(0, 0, '0, '0);
    set_ext(0, 0, '0, '0);
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_gnt_count", {24'd0, gnt_count}, 32'd0);
    chk("rst_rvalid", {31'd0, ext_bus.ext_rvalid}, 32'd0);
    chk("rst_rdata", ext_bus.ext_rdata, 32'd0);
    chk("rst_wait_cnt", 32'(dbg_wait_cnt), 32'd0);
    chk("rst_gnt", {31'd0, ext_bus.ext_gnt}, 32'd0);
    chk("rst_stall", {31'd0, core_stall}, 32'd0);

    // 1: idle core, write then read addr 5, then write addr 7
    set_ext(1, 1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("t1_wr_gnt", {31'd0, ext_bus.ext_gnt}, 32'd1);
    chk("t1_wr_ram_we", {31'd0, ram_we}, 32'd1);
    chk("t1_wr_ram_addr", 32'(ram_addr), 32'd5);
    chk("t1_wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
    chk("t1_wr_stall", {31'd0, core_stall}, 32'd0);
    cyc();
    set_ext(1, 0, 5'd5, 32'h0);
    #1;
    chk("t1_rd_gnt", {31'd0, ext_bus.ext_gnt}, 32'd1);
    chk("t1_rd_ram_we", {31'd0, ram_we}, 32'd0);
    chk("t1_wr_no_rvalid", {31'd0, ext_bus.ext_rvalid}, 32'd0);
    cyc();
    set_ext(1, 1, 5'd7, 32'h00007777);
    #1;
    chk("t1_b2b_gnt", {31'd0, ext_bus.ext_gnt}, 32'd1);
    chk("t1_rvalid", {31'd0, ext_bus.ext_rvalid}, 32'd1);
    chk("t1_rdata", ext_bus.ext_rdata, 32'hDEADBEEF);
    chk("t1_gnt_count", {24'd0, gnt_count}, 32'd2);
    cyc();
    set_ext(0, 0, '0, '0);
    #1;
    chk("t1_idle_gnt", {31'd0, ext_bus.ext_gnt}, 32'd0);
    chk("t1_rvalid_once", {31'd0, ext_bus.ext_rvalid}, 32'd0);
    chk("t1_gnt_count3", {24'd0, gnt_count}, 32'd3);
    chk("t1_ram7", ram[7], 32'h00007777);

    // 2: core loads every cycle while ext read waits
    set_core(0, 1, 5'd7, '0);
    set_ext(1, 0, 5'd5, '0);
    for (int i = 0; i < LIM; i++) begin
      #1;
      chk($sformatf("t2_wait%0d_gnt", i), {31'd0, ext_bus.ext_gnt}, 32'd0);
      chk($sformatf("t2_wait%0d_cnt", i), 32'(dbg_wait_cnt), i);
      cyc();
    end
    #1;
    chk("t2_forced_gnt", {31'd0, ext_bus.ext_gnt}, 32'd1);
    chk("t2_forced_stall", {31'd0, core_stall}, 32'd1);
    cyc();
    set_ext(0, 0, '0, '0);
    #1;
    chk("t2_owed_gnt", {31'd0, ext_bus.ext_gnt}, 32'd0);
    chk("t2_owed_stall", {31'd0, core_stall}, 32'd0);
    chk("t2_owed_flag", {31'd0, dbg_core_owed}, 32'd1);
    chk("t2_core_rdata", core_rdata, 32'h00007777);
    chk("t2_rvalid", {31'd0, ext_bus.ext_rvalid}, 32'd1);
    chk("t2_rdata", ext_bus.ext_rdata, 32'hDEADBEEF);
    chk("t2_wait_clr", 32'(dbg_wait_cnt), 32'd0);
    cyc();

    // 3: forced ext write collides with a core store to the same address
    set_core(0, 1, 5'd3, '0);
    set_ext(1, 1, 5'd3, 32'h22);
    repeat (LIM) cyc();
    set_core(1, 0, 5'd3, 32'h11);
    #1;
    chk("t3_gnt", {31'd0, ext_bus.ext_gnt}, 32'd1);
    chk("t3_stall", {31'd0, core_stall}, 32'd1);
    chk("t3_ram_wdata", ram_wdata, 32'h22);
    chk("t3_ram_addr", 32'(ram_addr), 32'd3);
    cyc();
    set_ext(0, 0, '0, '0);
    #1;
    chk("t3_ram3_ext", ram[3], 32'h22);
    chk("t3_retry_stall", {31'd0, core_stall}, 32'd0);
    chk("t3_retry_we", {31'd0, ram_we}, 32'd1);
    chk("t3_retry_wdata", ram_wdata, 32'h11);
    cyc();
    set_core(0, 0, '0, '0);
    #1;
    chk("t3_ram3_core", ram[3], 32'h11);

    // 4: request withdrawn after 2 wait cycles restarts the count
    set_core(0, 1, 5'd3, '0);
    set_ext(1, 0, 5'd3, '0);
    cyc(); cyc();
    chk("t4_wait2", 32'(dbg_wait_cnt), 32'd2);
    set_ext(0, 0, 5'd3, '0);
    cyc();
    chk("t4_wait_clr", 32'(dbg_wait_cnt), 32'd0);
    set_ext(1, 0, 5'd3, '0);
    for (int i = 0; i < LIM; i++) begin
      #1;
      chk($sformatf("t4_re%0d_gnt", i), {31'd0, ext_bus.ext_gnt}, 32'd0);
      cyc();
    end
    #1;
    chk("t4_forced_gnt", {31'd0, ext_bus.ext_gnt}, 32'd1);
    cyc();
    set_ext(0, 0, '0, '0);
    #1;
    chk("t4_rdata", ext_bus.ext_rdata, 32'h11);
    chk("t4_gnt_count", {24'd0, gnt_count}, 32'd6);
    cyc();
    set_core(0, 0, '0, '0);

    // 5: reset lands on a read grant with wait_cnt at 3
    set_core(0, 1, 5'd7, '0);
    set_ext(1, 0, 5'd5, '0);
    cyc(); cyc(); cyc();
    chk("t5_wait3", 32'(dbg_wait_cnt), 32'd3);
    set_core(0, 0, '0, '0);
    reset = 1'b1;
    #1;
    chk("t5_gnt_in_flight", {31'd0, ext_bus.ext_gnt}, 32'd1);
    cyc();
    reset = 1'b0;
    #1;
    chk("t5_rvalid", {31'd0, ext_bus.ext_rvalid}, 32'd0);
    chk("t5_wait", 32'(dbg_wait_cnt), 32'd0);
    chk("t5_gnt_count", {24'd0, gnt_count}, 32'd0);
    chk("t5_regrant", {31'd0, ext_bus.ext_gnt}, 32'd1);
    cyc();
    set_ext(0, 0, '0, '0);
    #1;
    chk("t5_rvalid_after", {31'd0, ext_bus.ext_rvalid}, 32'd1);
    chk("t5_rdata_after", ext_bus.ext_rdata, 32'hDEADBEEF);
    chk("t5_gnt_count1", {24'd0, gnt_count}, 32'd1);

    // 6: 256 random ext accesses against random core traffic
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < RAM_DEPTH; i++) exp_mem[i] = '0;
    exp_mem[3] = 32'h11;
    exp_mem[5] = 32'hDEADBEEF;
    exp_mem[7] = 32'h00007777;
    grants = 0; cycles = 0; ext_wait = 0;
    ext_pending = 1'b0; core_retry = 1'b0; prev_stall = 1'b0;
    while (grants < 256 && cycles < 5000) begin
      if (!core_retry) begin
        op = $urandom_range(0, 2);
        set_core(op == 2, op == 1, AW'($urandom_range(0, RAM_DEPTH - 1)), $urandom);
      end
      if (!ext_pending) begin
        set_ext(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, RAM_DEPTH - 1)), $urandom);
        ext_pending = 1'b1;
        ext_wait = 0;
      end
      #1;
      if (ext_bus.ext_rvalid) begin
        if (exp_q.size() == 0) chk("t6_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          popped = exp_q.pop_front();
          chk("t6_ext_rdata", ext_bus.ext_rdata, popped);
        end
      end
      if (core_re && !core_stall) chk("t6_core_rdata", core_rdata, exp_mem[core_addr]);
      if (prev_stall) chk("t6_no_b2b_stall", {31'd0, core_stall}, 32'd0);
      ext_wait++;
      if (ext_bus.ext_gnt) begin
        tests_run++;
        assert (ext_wait <= LIM + 1) else begin
          tests_failed++;
          $error("FAIL t6_latency observed=%0d expected<=%0d", ext_wait, LIM + 1);
        end
        if (ext_bus.ext_we) exp_mem[ext_bus.ext_addr] = ext_bus.ext_wdata;
        else exp_q.push_back(exp_mem[ext_bus.ext_addr]);
        grants++;
        ext_pending = 1'b0;
      end else begin
        tests_run++;
        assert (ext_wait < LIM + 1) else begin
          tests_failed++;
          $error("FAIL t6_wait_bound observed=%0d expected<%0d", ext_wait, LIM + 1);
        end
      end
      if (core_we && !core_stall) exp_mem[core_addr] = core_wdata;
      core_retry = core_stall;
      prev_stall = core_stall;
      cycles++;
      cyc();
    end
    set_ext(0, 0, '0, '0);
    set_core(0, 0, '0, '0);
    chk("t6_all_granted", grants, 32'd256);
    #1;
    if (ext_bus.ext_rvalid) begin
      if (exp_q.size() == 0) chk("t6_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        popped = exp_q.pop_front();
        chk("t6_ext_rdata", ext_bus.ext_rdata, popped);
      end
    end
    chk("t6_gnt_count_wrap", {24'd0, gnt_count}, 32'd0);
    chk("t6_reads_drained", exp_q.size(), 32'd0);
    cyc();
    bad_words = 0;
    for (int i = 0; i < RAM_DEPTH; i++) if (ram[i] !== exp_mem[i]) bad_words++;
    chk("t6_ram_contents", bad_words, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
